uart_rx_param: RTL and testbench

Parametrised oversampling UART receiver, successor to the fixed 8N1 receiver in the CFM link path.
- Configurable data width, parity mode, stop-bit count, oversample ratio and valid-hold length.
- Mid-bit sampling, false-start rejection, parity and framing error flags, break-safe re-arm.
- Sits between the async rx pin and the frame decoder; oversample timing comes from an external tick enable.

---
 rtl/uart_rx_param.sv | 232 +++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver.
// Mid-bit sampling on an external oversample tick, false-start rejection,
// parity/framing error flags and a break-safe re-arm flag. Outputs are
// registered and held stable until the next frame completes.
module uart_rx_param #(
    parameter int OVS        = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int VALID_HOLD = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 iTick,
    input  logic                 rx,
    output logic                 oValid,
    output logic [DATA_BITS-1:0] oData,
    output logic                 oParityErr,
    output logic                 oFrameErr,
    output logic                 oBusy
);
    localparam int TW = $clog2(OVS);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam int HW = $clog2(VALID_HOLD + 1);

    localparam logic [TW-1:0] TICK_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0] TICK_MID  = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] TICK_END  = TW'(OVS - 1);
    localparam logic [BW-1:0] BIT_ZERO  = {BW{1'b0}};
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic [HW-1:0] HOLD_ZERO = {HW{1'b0}};
    localparam logic [HW-1:0] HOLD_LEN  = HW'(VALID_HOLD);
    // Value the XOR of data and parity bit must take for a clean frame.
    localparam logic          ODD_PAR   = (PARITY == 2) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] v);
        return ^v;
    endfunction

    state_e                 state_q,    state_d;
    logic                   rx_meta_q,  rx_meta_d;
    logic                   rx_s_q,     rx_s_d;
    logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]          bit_cnt_q,  bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q,    shift_d;
    logic                   perr_acc_q, perr_acc_d;
    logic                   ferr_acc_q, ferr_acc_d;
    logic                   armed_q,    armed_d;
    logic [DATA_BITS-1:0]   data_q,     data_d;
    logic                   perr_q,     perr_d;
    logic                   ferr_q,     ferr_d;
    logic [HW-1:0]          hold_cnt_q, hold_cnt_d;
    logic                   valid_q,    valid_d;
    logic                   busy_q,     busy_d;
    logic                   mid_start_s;
    logic                   bit_mid_s;
    logic                   load_s;
    logic                   ferr_now_s;

    // Next-state logic: synchroniser, frame FSM, armed flag and valid hold.
    always_comb begin
        rx_meta_d   = rx;
        rx_s_d      = rx_meta_q;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        perr_acc_d  = perr_acc_q;
        ferr_acc_d  = ferr_acc_q;
        data_d      = data_q;
        perr_d      = perr_q;
        ferr_d      = ferr_q;
        load_s      = 1'b0;
        ferr_now_s  = 1'b0;
        mid_start_s = iTick && (tick_cnt_q == TICK_MID);
        bit_mid_s   = iTick && (tick_cnt_q == TICK_END);

        // Tick counter free-runs on iTick while a frame is in progress;
        // bit boundaries below pull it back to zero.
        if (iTick && (state_q != ST_IDLE)) begin
            tick_cnt_d = tick_cnt_q + TW'(1);
        end else begin
            tick_cnt_d = tick_cnt_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (!rx_s_q && armed_q) begin
                    state_d    = ST_START;
                    tick_cnt_d = TICK_ZERO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (mid_start_s) begin
                    tick_cnt_d = TICK_ZERO;
                    bit_cnt_d  = BIT_ZERO;
                    perr_acc_d = 1'b0;
                    ferr_acc_d = 1'b0;
                    // A line back high at mid start bit was only a glitch.
                    state_d    = rx_s_q ? ST_IDLE : ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_mid_s) begin
                    tick_cnt_d = TICK_ZERO;
                    shift_d    = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = BIT_ZERO;
                        state_d   = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        state_d   = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_mid_s) begin
                    tick_cnt_d = TICK_ZERO;
                    perr_acc_d = (parity_of(shift_q) ^ rx_s_q) != ODD_PAR;
                    state_d    = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (bit_mid_s) begin
                    tick_cnt_d = TICK_ZERO;
                    ferr_now_s = ferr_acc_q | ~rx_s_q;
                    ferr_acc_d = ferr_now_s;
                    if (bit_cnt_q == LAST_STOP) begin
                        state_d = ST_IDLE;
                        load_s  = 1'b1;
                        data_d  = shift_q;
                        perr_d  = perr_acc_q;
                        ferr_d  = ferr_now_s;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        state_d   = ST_STOP;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                tick_cnt_d = TICK_ZERO;
                bit_cnt_d  = BIT_ZERO;
            end
        endcase

        // A frame ending in a framing error disarms the receiver until the
        // line has been seen idle, so a held break cannot retrigger.
        if (load_s && ferr_now_s) begin
            armed_d = 1'b0;
        end else if (rx_s_q) begin
            armed_d = 1'b1;
        end else begin
            armed_d = armed_q;
        end

        // Hold counter runs on clk, independent of the FSM; a new frame
        // completing during the hold reloads it.
        if (load_s) begin
            hold_cnt_d = HOLD_LEN;
        end else if (hold_cnt_q != HOLD_ZERO) begin
            hold_cnt_d = hold_cnt_q - HW'(1);
        end else begin
            hold_cnt_d = hold_cnt_q;
        end

        valid_d = (hold_cnt_d != HOLD_ZERO);
        busy_d  = (state_d != ST_IDLE);
    end

    // State register with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            tick_cnt_q <= TICK_ZERO;
            bit_cnt_q  <= BIT_ZERO;
            shift_q    <= {DATA_BITS{1'b0}};
            perr_acc_q <= 1'b0;
            ferr_acc_q <= 1'b0;
            armed_q    <= 1'b1;
            data_q     <= {DATA_BITS{1'b0}};
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            hold_cnt_q <= HOLD_ZERO;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_meta_q  <= rx_meta_d;
            rx_s_q     <= rx_s_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            perr_acc_q <= perr_acc_d;
            ferr_acc_q <= ferr_acc_d;
            armed_q    <= armed_d;
            data_q     <= data_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            hold_cnt_q <= hold_cnt_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
        end
    end

    assign oValid     = valid_q;
    assign oData      = data_q;
    assign oParityErr = perr_q;
    assign oFrameErr  = ferr_q;
    assign oBusy      = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations driven with directed and
// random frames; expected frames go into per-instance queues and monitors
// compare them when oValid rises.
module tb_uart_rx_param;

    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        longint     rise;
    } exp_t;

    // Instance configurations: 0 = 8N1/OVS16, 1 = 7E1/OVS8/hold1, 2 = 8O2/OVS16/tick/4.
    int cfg_ovs[3] = '{16, 8, 16};
    int cfg_db[3]  = '{8, 7, 8};
    int cfg_par[3] = '{0, 1, 2};
    int cfg_sb[3]  = '{1, 1, 2};
    int cfg_vh[3]  = '{3, 1, 4};
    int cfg_div[3] = '{1, 1, 4};

    logic       clk;
    logic       rst;
    logic       rx_line [3];
    logic       tick    [3];
    logic       o_valid [3];
    logic       o_perr  [3];
    logic       o_ferr  [3];
    logic       o_busy  [3];
    logic [7:0] d_a;
    logic [6:0] d_b;
    logic [7:0] d_c;

    longint cyc;
    int     checks;
    int     failures;
    exp_t   q_a[$];
    exp_t   q_b[$];
    exp_t   q_c[$];
    logic   prev_v [3];
    int     hi_cnt [3];

    uart_rx_param #(.OVS(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .VALID_HOLD(3)) u_a (
        .clk(clk), .rst(rst), .iTick(tick[0]), .rx(rx_line[0]), .oValid(o_valid[0]),
        .oData(d_a), .oParityErr(o_perr[0]), .oFrameErr(o_ferr[0]), .oBusy(o_busy[0]));

    uart_rx_param #(.OVS(8), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .VALID_HOLD(1)) u_b (
        .clk(clk), .rst(rst), .iTick(tick[1]), .rx(rx_line[1]), .oValid(o_valid[1]),
        .oData(d_b), .oParityErr(o_perr[1]), .oFrameErr(o_ferr[1]), .oBusy(o_busy[1]));

    uart_rx_param #(.OVS(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .VALID_HOLD(4)) u_c (
        .clk(clk), .rst(rst), .iTick(tick[2]), .rx(rx_line[2]), .oValid(o_valid[2]),
        .oData(d_c), .oParityErr(o_perr[2]), .oFrameErr(o_ferr[2]), .oBusy(o_busy[2]));

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter (number of posedges seen).
    always @(posedge clk) cyc <= cyc + 64'd1;

    // Oversample ticks; instance 2 gets one tick every fourth clk.
    initial begin
        int div;
        div = 0;
        tick[0] = 1'b1;
        tick[1] = 1'b1;
        tick[2] = 1'b1;
        forever begin
            @(negedge clk);
            div = (div + 1) % 4;
            tick[2] = (div == 0);
        end
    end

    // Watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: expected outputs from the line content of one frame.
    task automatic push_expect(input int idx, input logic [8:0] data, input logic pbit,
                               input logic [1:0] stops, input longint rise);
        exp_t e;
        int   ones;
        e.data = data;
        ones = $countones(data) + int'(pbit);
        if (cfg_par[idx] == 1)      e.perr = (ones % 2) != 0;
        else if (cfg_par[idx] == 2) e.perr = (ones % 2) == 0;
        else                        e.perr = 1'b0;
        e.ferr = 1'b0;
        for (int s = 0; s < cfg_sb[idx]; s++) if (stops[s] == 1'b0) e.ferr = 1'b1;
        e.rise = rise;
        case (idx)
            0: q_a.push_back(e);
            1: q_b.push_back(e);
            default: q_c.push_back(e);
        endcase
    endtask

    // Drive one complete frame on instance idx, then gap_bits idle bit times.
    task automatic send_frame(input int idx, input logic [8:0] data_in, input bit bad_par,
                              input logic [1:0] stops, input int gap_bits);
        logic       bits[$];
        logic [8:0] data;
        logic       pbit;
        int         bclk;
        longint     t0;
        data = data_in & ((9'd1 << cfg_db[idx]) - 9'd1);
        bclk = cfg_ovs[idx] * cfg_div[idx];
        pbit = ($countones(data) % 2 == 1) ? 1'b1 : 1'b0;
        if (cfg_par[idx] == 2) pbit = ~pbit;
        pbit = pbit ^ bad_par;
        bits.push_back(1'b0);
        for (int i = 0; i < cfg_db[idx]; i++) bits.push_back(data[i]);
        if (cfg_par[idx] != 0) bits.push_back(pbit);
        for (int s = 0; s < cfg_sb[idx]; s++) bits.push_back(stops[s]);
        @(posedge clk);
        #1;
        t0 = cyc;
        // Instance 0 ticks every clk: 3 clk to reach START, 8 ticks to mid
        // start bit, then 9 full bits to the stop-bit sample.
        push_expect(idx, data, pbit, stops, (idx == 0) ? t0 + 64'd155 : -64'd1);
        foreach (bits[i]) begin
            rx_line[idx] = bits[i];
            repeat (bclk) @(posedge clk);
            #1;
        end
        if (gap_bits > 0) begin
            rx_line[idx] = 1'b1;
            repeat (gap_bits * bclk) @(posedge clk);
        end
    endtask

    task automatic rand_frame(input int idx);
        logic [8:0] d;
        bit         bp;
        logic [1:0] st;
        int         gap;
        d  = 9'($urandom);
        bp = ($urandom_range(0, 3) == 0);
        st = 2'b11;
        if ($urandom_range(0, 4) == 0) st = 2'($urandom_range(0, 2));
        gap = (st[cfg_sb[idx] - 1] == 1'b0) ? 1 : int'($urandom_range(0, 1));
        send_frame(idx, d, bp, st, gap);
    endtask

    // Monitor: on oValid rise pop the expected frame and compare; on fall
    // check how long oValid stayed high.
    task automatic mon(input int idx, input logic v, input logic [8:0] d,
                       input logic pe, input logic fe);
        exp_t e;
        bit   have;
        have = 1'b0;
        if (v === 1'b1 && prev_v[idx] !== 1'b1) begin
            case (idx)
                0: if (q_a.size() > 0) begin e = q_a.pop_front(); have = 1'b1; end
                1: if (q_b.size() > 0) begin e = q_b.pop_front(); have = 1'b1; end
                default: if (q_c.size() > 0) begin e = q_c.pop_front(); have = 1'b1; end
            endcase
            if (!have) begin
                chk($sformatf("unexpected_valid[%0d]", idx), 64'd1, 64'd0);
            end else begin
                chk($sformatf("data[%0d]", idx), 64'(d), 64'(e.data));
                chk($sformatf("parity_err[%0d]", idx), 64'(pe), 64'(e.perr));
                chk($sformatf("frame_err[%0d]", idx), 64'(fe), 64'(e.ferr));
                if (e.rise >= 0) chk($sformatf("latency[%0d]", idx), 64'(cyc), 64'(e.rise));
            end
        end
        if (v === 1'b1) begin
            hi_cnt[idx]++;
        end else if (prev_v[idx] === 1'b1) begin
            chk($sformatf("valid_hold[%0d]", idx), 64'(hi_cnt[idx]), 64'(cfg_vh[idx]));
            hi_cnt[idx] = 0;
        end
        prev_v[idx] = v;
    endtask

    always @(negedge clk) mon(0, o_valid[0], 9'(d_a), o_perr[0], o_ferr[0]);
    always @(negedge clk) mon(1, o_valid[1], 9'(d_b), o_perr[1], o_ferr[1]);
    always @(negedge clk) mon(2, o_valid[2], 9'(d_c), o_perr[2], o_ferr[2]);

    task automatic check_reset_state(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_valid[%0d]", tag, i), 64'(o_valid[i]), 64'd0);
            chk($sformatf("%s_busy[%0d]", tag, i), 64'(o_busy[i]), 64'd0);
            chk($sformatf("%s_perr[%0d]", tag, i), 64'(o_perr[i]), 64'd0);
            chk($sformatf("%s_ferr[%0d]", tag, i), 64'(o_ferr[i]), 64'd0);
        end
        chk({tag, "_data[0]"}, 64'(d_a), 64'd0);
        chk({tag, "_data[1]"}, 64'(d_b), 64'd0);
        chk({tag, "_data[2]"}, 64'(d_c), 64'd0);
    endtask

    initial begin
        int n;
        cyc = 0;
        checks = 0;
        failures = 0;
        for (int i = 0; i < 3; i++) begin
            rx_line[i] = 1'b1;
            prev_v[i]  = 1'b0;
            hi_cnt[i]  = 0;
        end
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;
        repeat (4) @(posedge clk);

        // Basic 8N1 frame with latency check.
        send_frame(0, 9'h0A5, 1'b0, 2'b11, 2);

        // Glitch of 5 clk on the line: no frame, back to idle quickly.
        @(posedge clk);
        #1;
        rx_line[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("glitch_busy", 64'(o_busy[0]), 64'd1);
        rx_line[0] = 1'b1;
        n = 0;
        while (o_busy[0] && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("glitch_idle", 64'(o_busy[0]), 64'd0);
        repeat (40) @(posedge clk);

        // Even parity, 7 data bits: wrong parity bit, then a clean frame.
        send_frame(1, 9'h041, 1'b1, 2'b11, 2);
        send_frame(1, 9'h041, 1'b0, 2'b11, 2);

        // Framing error followed by a 40-bit-time break, then a clean frame.
        send_frame(0, 9'h03C, 1'b0, 2'b00, 0);
        repeat (40 * 16) @(posedge clk);
        #1;
        rx_line[0] = 1'b1;
        repeat (32) @(posedge clk);
        send_frame(0, 9'h012, 1'b0, 2'b11, 2);

        // Reset during data bit 4 of 0xFF, then 0x81.
        @(posedge clk);
        #1;
        rx_line[0] = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        rx_line[0] = 1'b1;
        repeat (72) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state("midframe_reset");
        repeat (120) @(posedge clk);
        send_frame(0, 9'h081, 1'b0, 2'b11, 2);

        // Two stop bits, slow tick: 0x00 and 0xFF back to back.
        send_frame(2, 9'h000, 1'b0, 2'b11, 0);
        send_frame(2, 9'h0FF, 1'b0, 2'b11, 2);

        // Random traffic on all three instances concurrently.
        fork
            for (int i = 0; i < 24; i++) rand_frame(0);
            for (int i = 0; i < 30; i++) rand_frame(1);
            for (int i = 0; i < 10; i++) rand_frame(2);
        join
        for (int i = 0; i < 3; i++) rx_line[i] = 1'b1;
        repeat (200) @(posedge clk);
        #1;

        chk("pending_frames[0]", 64'(q_a.size()), 64'd0);
        chk("pending_frames[1]", 64'(q_b.size()), 64'd0);
        chk("pending_frames[2]", 64'(q_c.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
